// File: rtl/ivl_uvm_ovl_zero_one_hot_stim.sv
// Stimulus driver and scoreboard for an ovl_zero_one_hot checker: drives zero/one-hot
// and two-hot vectors, predicts the checker's fire bit and counts disagreements.
module ivl_uvm_ovl_zero_one_hot_stim #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned ILLEGAL_EVERY = 4,
  parameter int unsigned FIRE_LATENCY  = 1,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             fire_i,
  output logic             enable_o,
  output logic [WIDTH-1:0] test_expr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [15:0]      vec_count_o,
  output logic [15:0]      fire_count_o,
  output logic [15:0]      mismatch_count_o
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam int unsigned ILL_DIV  = (ILLEGAL_EVERY == 0) ? 1 : ILLEGAL_EVERY;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [WIDTH-1:0]        test_expr_q, test_expr_d;
  logic                    ill_q, ill_d;
  logic                    enable_q, enable_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [15:0]             vec_q, vec_d;
  logic [15:0]             fire_cnt_q, fire_cnt_d;
  logic [15:0]             mism_q, mism_d;
  logic [FIRE_LATENCY-1:0] pexp_q, pexp_d;
  logic [FIRE_LATENCY-1:0] pvld_q, pvld_d;
  logic [1:0]              drain_q, drain_d;

  logic [15:0]      idx_c;
  logic [4:0]       p_c, p1_c;
  logic             illegal_c;
  logic [WIDTH-1:0] vec_c;
  logic [15:0]      lfsr_next_c;
  logic             load_c;

  // Candidate vector for the next index, derived from the current LFSR state
  always_comb begin
    idx_c       = (state_q == DRIVE) ? vec_q + 16'd1 : 16'd1;
    p_c         = 5'(32'(lfsr_q[4:0]) % WIDTH);
    p1_c        = 5'((32'(p_c) + 32'd1) % WIDTH);
    illegal_c   = (ILLEGAL_EVERY != 0) && ((32'(idx_c) % ILL_DIV) == 32'd0);
    lfsr_next_c = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    if (illegal_c) begin
      vec_c = (WIDTH'(1) << p_c) | (WIDTH'(1) << p1_c);
    end else if (lfsr_q[15]) begin
      vec_c = '0;
    end else begin
      vec_c = WIDTH'(1) << p_c;
    end
  end

  // Next-state, scoreboard and registered-output logic
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    test_expr_d = '0;
    ill_d       = 1'b0;
    done_d      = done_q;
    pass_d      = pass_q;
    vec_d       = vec_q;
    fire_cnt_d  = fire_cnt_q;
    mism_d      = mism_q;
    pexp_d      = pexp_q;
    pvld_d      = pvld_q;
    drain_d     = drain_q;
    load_c      = 1'b0;

    if (state_q == DRIVE || state_q == DRAIN) begin
      if (fire_i && fire_cnt_q != CNT_MAX) fire_cnt_d = fire_cnt_q + 16'd1;
      if (pvld_q[FIRE_LATENCY-1] && (fire_i != pexp_q[FIRE_LATENCY-1]) && mism_q != CNT_MAX)
        mism_d = mism_q + 16'd1;
      for (int i = 1; i < FIRE_LATENCY; i++) begin
        pexp_d[i] = pexp_q[i-1];
        pvld_d[i] = pvld_q[i-1];
      end
      pexp_d[0] = ill_q;
      pvld_d[0] = (state_q == DRIVE);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = DRIVE;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          vec_d      = 16'd1;
          fire_cnt_d = '0;
          mism_d     = '0;
          pexp_d     = '0;
          pvld_d     = '0;
          load_c     = 1'b1;
        end
      end
      DRIVE: begin
        if (vec_q == 16'(NUM_VECTORS)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          vec_d  = vec_q + 16'd1;
          load_c = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(FIRE_LATENCY - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (mism_d == 16'd0);
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      test_expr_d = vec_c;
      ill_d       = illegal_c;
      lfsr_d      = lfsr_next_c;
    end
    enable_d = (state_d == DRIVE) || (state_d == DRAIN);
    busy_d   = enable_d;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      test_expr_q <= '0;
      ill_q       <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      vec_q       <= '0;
      fire_cnt_q  <= '0;
      mism_q      <= '0;
      pexp_q      <= '0;
      pvld_q      <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      test_expr_q <= test_expr_d;
      ill_q       <= ill_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      vec_q       <= vec_d;
      fire_cnt_q  <= fire_cnt_d;
      mism_q      <= mism_d;
      pexp_q      <= pexp_d;
      pvld_q      <= pvld_d;
      drain_q     <= drain_d;
    end
  end

  assign enable_o         = enable_q;
  assign test_expr_o      = test_expr_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign vec_count_o      = vec_q;
  assign fire_count_o     = fire_cnt_q;
  assign mismatch_count_o = mism_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_zero_one_hot_stim.sv
// Directed bench: three driver instances, each with a behavioural zero-one-hot checker.
module tb_ivl_uvm_ovl_zero_one_hot_stim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] fmode = 2'd0;  // 0: real checker on instance a, 1: fire tied 0, 2: fire tied 1

  logic       en_a, busy_a, done_a, pass_a, fire_a;
  logic [3:0] te_a;
  logic [15:0] vec_a, fc_a, mm_a;
  logic       en_b, busy_b, done_b, pass_b;
  logic [3:0] te_b;
  logic [15:0] vec_b, fc_b, mm_b;
  logic       en_c, busy_c, done_c, pass_c;
  logic [3:0] te_c;
  logic [15:0] vec_c, fc_c, mm_c;

  logic chk_a = 1'b0, chk_b = 1'b0, chk_c = 1'b0;

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  // Behavioural checkers, one-cycle fire latency
  always @(posedge clk) begin
    chk_a <= rst_n && en_a && multi_hot(te_a);
    chk_b <= rst_n && en_b && multi_hot(te_b);
    chk_c <= rst_n && en_c && multi_hot(te_c);
  end

  assign fire_a = (fmode == 2'd0) ? chk_a : (fmode == 2'd2);

  ivl_uvm_ovl_zero_one_hot_stim #(.WIDTH(4), .NUM_VECTORS(8), .ILLEGAL_EVERY(4),
    .FIRE_LATENCY(1), .SEED(16'hACE1)) u_a (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .fire_i(fire_a),
    .enable_o(en_a), .test_expr_o(te_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .vec_count_o(vec_a), .fire_count_o(fc_a), .mismatch_count_o(mm_a));

  ivl_uvm_ovl_zero_one_hot_stim #(.WIDTH(4), .NUM_VECTORS(16), .ILLEGAL_EVERY(0),
    .FIRE_LATENCY(1), .SEED(16'hACE1)) u_b (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .fire_i(chk_b),
    .enable_o(en_b), .test_expr_o(te_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .vec_count_o(vec_b), .fire_count_o(fc_b), .mismatch_count_o(mm_b));

  ivl_uvm_ovl_zero_one_hot_stim #(.WIDTH(4), .NUM_VECTORS(5), .ILLEGAL_EVERY(1),
    .FIRE_LATENCY(1), .SEED(16'h0000)) u_c (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .fire_i(chk_c),
    .enable_o(en_c), .test_expr_o(te_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
    .vec_count_o(vec_c), .fire_count_o(fc_c), .mismatch_count_o(mm_c));

  int n_vec = 0;
  int n_err = 0;
  int nb_a, nb_b, nb_c;
  logic [3:0] log_a [1:16];
  logic [3:0] log_c [1:16];
  // Hand-derived from the Galois LFSR sequence starting at 16'hACE1
  logic [3:0] exp_a  [1:8] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h4, 4'h8, 4'h0, 4'h6};
  logic [3:0] exp_c2 [1:5] = '{4'h9, 4'h9, 4'h6, 4'h3, 4'hC};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then log one sample per cycle until all instances are done
  task automatic run(input int restart_at);
    logic all_done;
    nb_a = 0; nb_b = 0; nb_c = 0;
    all_done = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy_a) nb_a++;
      if (busy_b) nb_b++;
      if (busy_c) nb_c++;
      if (k <= 16) begin
        log_a[k] = te_a;
        log_c[k] = te_c;
      end
      start = (k == restart_at);
      if (done_a && done_b && done_c) begin
        all_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_completes", 32'(all_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_test_expr", 32'(te_a), 32'd0);
    chk("rst_enable", 32'(en_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_vec_count", 32'(vec_a), 32'd0);
    chk("rst_fire_count", 32'(fc_a), 32'd0);
    chk("rst_mismatch", 32'(mm_a), 32'd0);
    rst_n = 1'b1;

    // Basic run with a stray start during DRIVE
    run(3);
    for (int i = 1; i <= 8; i++) chk($sformatf("a_vec%0d", i), 32'(log_a[i]), 32'(exp_a[i]));
    chk("a_busy_cycles", 32'(nb_a), 32'd9);
    chk("a_vec_count", 32'(vec_a), 32'd8);
    chk("a_fire_count", 32'(fc_a), 32'd2);
    chk("a_mismatch", 32'(mm_a), 32'd0);
    chk("a_done", 32'(done_a), 32'd1);
    chk("a_pass", 32'(pass_a), 32'd1);
    chk("a_idle_test_expr", 32'(te_a), 32'd0);
    chk("a_idle_enable", 32'(en_a), 32'd0);
    chk("b_busy_cycles", 32'(nb_b), 32'd17);
    chk("b_vec_count", 32'(vec_b), 32'd16);
    chk("b_fire_count", 32'(fc_b), 32'd0);
    chk("b_mismatch", 32'(mm_b), 32'd0);
    chk("b_pass", 32'(pass_b), 32'd1);
    for (int i = 1; i <= 5; i++) chk($sformatf("c_popcount%0d", i), 32'($countones(log_c[i])), 32'd2);
    chk("c_busy_cycles", 32'(nb_c), 32'd6);
    chk("c_fire_count", 32'(fc_c), 32'd5);
    chk("c_mismatch", 32'(mm_c), 32'd0);
    chk("c_pass", 32'(pass_c), 32'd1);

    // Fire stuck low; instance c continues its LFSR and hits the MSB wrap
    fmode = 2'd1;
    run(0);
    chk("f0_mismatch", 32'(mm_a), 32'd2);
    chk("f0_fire_count", 32'(fc_a), 32'd0);
    chk("f0_pass", 32'(pass_a), 32'd0);
    for (int i = 1; i <= 5; i++) chk($sformatf("c_run2_vec%0d", i), 32'(log_c[i]), 32'(exp_c2[i]));
    chk("c_run2_pass", 32'(pass_c), 32'd1);

    // Fire stuck high
    fmode = 2'd2;
    run(0);
    chk("f1_mismatch", 32'(mm_a), 32'd6);
    chk("f1_fire_count", 32'(fc_a), 32'd9);
    chk("f1_pass", 32'(pass_a), 32'd0);
    fmode = 2'd0;

    // Reset in the middle of DRIVE
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_vec_count", 32'(vec_a), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_test_expr", 32'(te_a), 32'd0);
    chk("mid_rst_vec_count", 32'(vec_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_enable", 32'(en_a), 32'd0);
    start = 1'b1;
    @(negedge clk);
    chk("start_vs_reset_busy", 32'(busy_a), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    // LFSR was reseeded, so the first-run sequence repeats
    run(0);
    for (int i = 1; i <= 8; i++) chk($sformatf("reseed_vec%0d", i), 32'(log_a[i]), 32'(exp_a[i]));
    chk("reseed_fire_count", 32'(fc_a), 32'd2);
    chk("reseed_pass", 32'(pass_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ivl_uvm_ovl_zero_one_hot_stim.md
Name: ivl_uvm_ovl_zero_one_hot_stim

Overview:
- Self-checking stimulus driver for the ovl_zero_one_hot checker. It acts as the producer end of the checker's test_expr/fire interface.
- Drives a deterministic sequence of legal vectors (all-zero or one-hot) and illegal vectors (two bits set) onto test_expr.
- Predicts, for each cycle, whether the checker must fire, and compares that prediction against the checker's fire output.
- Instantiated beside the checker in OVL regression benches. It replaces hand-written vector lists and $display-only checking.

Parameters:
- WIDTH, 4, test_expr width; legal range is 2 to 32.
- NUM_VECTORS, 16, number of vectors driven per run; legal range is 1 to 65535.
- ILLEGAL_EVERY, 4, every Nth vector (1-based) is illegal; 0 means all vectors are legal.
- FIRE_LATENCY, 1, cycles from test_expr sample to the checker's fire output; legal range is 1 to 4.
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'hACE1.

Ports:
- clock, in, 1, sole clock; all logic on posedge.
- reset, in, 1, synchronous active-low reset.
- start, in, 1, single-cycle pulse that begins a run.
- enable, out, 1, drives the checker's enable input.
- test_expr, out, WIDTH, drives the checker's test_expr input.
- fire, in, 1, checker's assertion fire bit (fire[0]).
- busy, out, 1, high during DRIVE and DRAIN.
- done, out, 1, high in DONE until the next start or reset.
- pass, out, 1, valid while done; 1 when mismatch_count is 0.
- vec_count, out, 16, number of vectors driven so far.
- fire_count, out, 16, number of cycles on which fire was observed high during DRIVE/DRAIN; saturates at FFFF.
- mismatch_count, out, 16, number of compared cycles where fire differed from the prediction; saturates at FFFF.

Behaviour:
- Reset (reset==0 at posedge), which overrides everything including mid-run:
  - state goes to IDLE.
  - test_expr=0, enable=0, busy=0, done=0, pass=0.
  - All counters are cleared.
  - LFSR is loaded with SEED.
  - Prediction pipeline is flushed to invalid.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE: start -> DRIVE. Counters and pipeline are cleared on the same edge. LFSR is not reseeded, so back-to-back runs continue the sequence.
- DRIVE: one vector is registered onto test_expr per cycle and vec_count increments. After vector NUM_VECTORS is driven -> DRAIN.
- DRAIN: lasts exactly FIRE_LATENCY cycles with test_expr=0, then -> DONE.
- DONE: test_expr=0 and enable=0. start -> DRIVE, which clears done and the counters.
- start is ignored while busy.
- enable is 1 in DRIVE and DRAIN, 0 otherwise.
- Vector generation for vector index i (1-based). p = lfsr[4:0] mod WIDTH.
  - Illegal if ILLEGAL_EVERY!=0 and i mod ILLEGAL_EVERY==0. Vector is (1<<p) | (1<<((p+1) mod WIDTH)), i.e. exactly two bits set, wrapping at the MSB.
  - Otherwise, if lfsr[15]==1, the vector is all-zero.
  - Otherwise the vector is 1<<p.
- LFSR: 16-bit Galois, taps 16'hB400. It advances once per driven vector only.
- Prediction:
  - expected = 1 when the vector driven this cycle is illegal.
  - expected enters a FIRE_LATENCY-deep shift register with a valid bit. The valid bit is 1 only for DRIVE cycles.
  - DRAIN shifts in valid=0.
  - When the pipeline output is valid, fire is compared against it. A difference increments mismatch_count.
- fire_count counts fire==1 on every DRIVE/DRAIN cycle, independent of the compare.
- pass is registered on entry to DONE as (mismatch_count==0).
- After a completed run, the required invariant is fire_count == number of illegal vectors, i.e. NUM_VECTORS/ILLEGAL_EVERY (integer divide).
- Simultaneous start and reset: reset wins.

Test Plan:
- Basic run, WIDTH=4, NUM_VECTORS=8, ILLEGAL_EVERY=4, real checker attached, pulse start:
  - Every vector is 0 or one-hot, except vectors 4 and 8, which have popcount 2.
  - fire_count=2, mismatch_count=0, vec_count=8, done=1, pass=1.
  - busy is high for exactly 9 cycles.
- All-legal run, ILLEGAL_EVERY=0, NUM_VECTORS=16: fire_count=0, mismatch_count=0, pass=1.
- All-illegal run, ILLEGAL_EVERY=1, NUM_VECTORS=5: every test_expr has popcount 2; fire_count=5, pass=1.
- Wrap-around, WIDTH=4: when p=3 the illegal vector is 4'b1001.
- Fault injection:
  - Tie fire=0 with NUM_VECTORS=8, ILLEGAL_EVERY=4: mismatch_count=2, pass=0.
  - Tie fire=1 instead: mismatch_count=6, fire_count=9.
- Reset mid-DRIVE, then start again:
  - Reset asserted at vector 3: next edge gives IDLE, test_expr=0, vec_count=0, done=0.
  - Second start reproduces the first-run vector sequence, because the LFSR was reseeded.
- Start pulsed during DRIVE is ignored: vec_count still ends at NUM_VECTORS.
